turn_manager: RTL and testbench
===============================

Name: turn_manager

Overview:
- Per-turn controller for the pool game; sits directly upstream of the red-ball motion block.
- Watches shot start, ball-stopped flags and hole collisions, and decides turn end, scoring, player switch and respawn.
- Drives the single-cycle turn_over pulse and the new red/white ball locations that the motion blocks load on that pulse.

Parameters:
- RED_RESPAWN_X, 280, red ball topLeftX after a red pot
- RED_RESPAWN_Y, 185, red ball topLeftY after a red pot
- WHITE_RESPAWN_X, 120, white ball topLeftX after a white pot (foul)
- WHITE_RESPAWN_Y, 185, white ball topLeftY after a white pot
- SETTLE_FRAMES, 4, consecutive frames both balls must be stopped before the turn ends
- MIN_ROLL_FRAMES, 2, frames ignored after a shot before stop-checking starts
- MAX_TURN_FRAMES, 600, timeout in frames (only with TURN_TIMEOUT_EN)
- WIN_SCORE, 5, score that ends the game

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-clk pulse per frame
- shot_fired  in  1  one-clk pulse when the cue strikes the white ball
- red_ball_stopped  in  1  red Xspeed and Yspeed are both 0
- white_ball_stopped  in  1  white Xspeed and Yspeed are both 0
- collision_Red_Black  in  1  red ball inside a hole
- collision_White_Black  in  1  white ball inside a hole
- red_x_loc, red_y_loc  in  11 signed  current red topLeft
- white_x_loc, white_y_loc  in  11 signed  current white topLeft
- turn_over  out  1  one-clk pulse; new_* outputs are valid in the same cycle
- new_red_x_loc, new_red_y_loc  out  11 signed  red location to load
- new_white_x_loc, new_white_y_loc  out  11 signed  white location to load
- current_player  out  1  0/1, player whose turn it is
- score0, score1  out  4  per-player scores
- shot_enable  out  1  high only in AIM
- foul  out  1  high for the turn_over cycle if the white ball was potted
- game_over  out  1  sticky until reset

Behaviour:
- Reset: state AIM. All outputs 0 except shot_enable=1. Flags and counters 0. Reset is effective mid-operation, from any state.
- States:
  - AIM: shot_enable=1. shot_fired -> ROLL; clear pot flags and frame counters.
  - ROLL: count startOfFrame pulses. After MIN_ROLL_FRAMES frames -> SETTLE.
  - SETTLE: settle counter increments on startOfFrame when both stopped flags are high, and clears the same clk either flag is low. Reaching SETTLE_FRAMES -> EVAL.
  - EVAL (1 clk): apply the rules below, assert turn_over for this one cycle, then go to AIM, or to OVER if either score reaches WIN_SCORE.
  - OVER: shot_enable=0, game_over=1. Only reset exits.
- shot_fired outside AIM is ignored.
- Pot flags:
  - red_potted / white_potted are sticky over ROLL+SETTLE.
  - Set on any clk where the collision input is high.
- EVAL rules. Bumping current_player's score and player switch are registered in EVAL.
  - red_potted only: current_player score +1; new_red = RED_RESPAWN; player unchanged.
  - white_potted only: foul=1; other player score +1; new_white = WHITE_RESPAWN; player toggles.
  - Both potted: current player +1 and other player +1; both balls respawn; foul=1; player toggles.
  - Neither: new_red = red_x/y_loc and new_white = white_x/y_loc, sampled in EVAL; player toggles.
- Scores saturate at 15.
- new_* outputs hold their value until the next EVAL.

Optional Feature:
- Macro TURN_TIMEOUT_EN.
- Defined: frame counter runs from shot_fired. Reaching MAX_TURN_FRAMES in ROLL or SETTLE forces EVAL, with rules applied from the current flags.
- Undefined: no timeout; SETTLE waits indefinitely.

Test Plan:
- No pot: shot_fired, then both stopped for 4 frames at red=(300,200) -> turn_over 1 clk, new_red=(300,200), player 0->1, scores 0/0.
- Red pot: collision_Red_Black pulse in ROLL, then settle -> score0=1, new_red=(280,185), player stays 0, foul=0.
- White pot: collision_White_Black, then settle -> foul=1 in the turn_over cycle, score1=1, new_white=(120,185), player 0->1.
- Stop flicker: red_ball_stopped drops at settle frame 3 -> counter clears; turn_over only after 4 further consecutive stopped frames. shot_fired during SETTLE is ignored.
- Win/reset: score0=4 plus a red pot -> score0=5, game_over=1, shot_enable=0. resetN low mid-ROLL -> AIM, scores 0.
- TURN_TIMEOUT_EN defined, MAX_TURN_FRAMES=10, balls never stop -> turn_over on the 10th frame after the shot. Undefined -> no turn_over.

Source files
------------

// File: rtl/turn_manager.sv
// turn_manager: per-turn controller for the pool game (aim, roll, settle, evaluate, game over).
// Build option: define TURN_TIMEOUT_EN to force evaluation MAX_TURN_FRAMES frames after the shot.
module turn_manager #(
    parameter int          RED_RESPAWN_X   = 280,
    parameter int          RED_RESPAWN_Y   = 185,
    parameter int          WHITE_RESPAWN_X = 120,
    parameter int          WHITE_RESPAWN_Y = 185,
    parameter int unsigned SETTLE_FRAMES   = 4,
    parameter int unsigned MIN_ROLL_FRAMES = 2,
    parameter int unsigned MAX_TURN_FRAMES = 600,
    parameter int unsigned WIN_SCORE       = 5
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               shot_fired,
    input  logic               red_ball_stopped,
    input  logic               white_ball_stopped,
    input  logic               collision_Red_Black,
    input  logic               collision_White_Black,
    input  logic signed [10:0] red_x_loc,
    input  logic signed [10:0] red_y_loc,
    input  logic signed [10:0] white_x_loc,
    input  logic signed [10:0] white_y_loc,
    output logic               turn_over,
    output logic signed [10:0] new_red_x_loc,
    output logic signed [10:0] new_red_y_loc,
    output logic signed [10:0] new_white_x_loc,
    output logic signed [10:0] new_white_y_loc,
    output logic               current_player,
    output logic [3:0]         score0,
    output logic [3:0]         score1,
    output logic               shot_enable,
    output logic               foul,
    output logic               game_over
);
    // One counter width covers every frame count this block keeps.
    localparam int unsigned CW = $clog2(MAX_TURN_FRAMES + SETTLE_FRAMES + MIN_ROLL_FRAMES + 1);

    localparam logic [2:0] AIM    = 3'd0;
    localparam logic [2:0] ROLL   = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] EVAL   = 3'd3;
    localparam logic [2:0] OVER   = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [CW-1:0]      roll_cnt_q, settle_cnt_q;
    logic               red_potted_q, white_potted_q;
    logic               player_q;
    logic [3:0]         score0_q, score1_q, score0_d, score1_d;
    logic signed [10:0] hold_red_x_q, hold_red_y_q, hold_white_x_q, hold_white_y_q;
    logic signed [10:0] eval_red_x, eval_red_y, eval_white_x, eval_white_y;
    logic               rolling, both_stopped, settle_done, inc0, inc1, toggle, win;
    logic               timeout;

    assign rolling      = (state_q == ROLL) || (state_q == SETTLE);
    assign both_stopped = red_ball_stopped && white_ball_stopped;
    assign settle_done  = startOfFrame && both_stopped &&
                          (settle_cnt_q == CW'(SETTLE_FRAMES - 1));

`ifdef TURN_TIMEOUT_EN
    logic [CW-1:0] frame_cnt_q;

    assign timeout = rolling && startOfFrame && (frame_cnt_q == CW'(MAX_TURN_FRAMES - 1));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_cnt_q <= '0;
        end else if (state_q == AIM && shot_fired) begin
            frame_cnt_q <= '0;
        end else if (rolling && startOfFrame) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Shooter scores a red pot, opponent scores a white pot; both saturate at 15.
    assign inc0     = player_q ? white_potted_q : red_potted_q;
    assign inc1     = player_q ? red_potted_q : white_potted_q;
    assign score0_d = (inc0 && score0_q != 4'hF) ? score0_q + 4'd1 : score0_q;
    assign score1_d = (inc1 && score1_q != 4'hF) ? score1_q + 4'd1 : score1_q;
    assign win      = (32'(score0_d) >= WIN_SCORE) || (32'(score1_d) >= WIN_SCORE);
    assign toggle   = !red_potted_q || white_potted_q;

    assign eval_red_x   = red_potted_q ? 11'(RED_RESPAWN_X) : red_x_loc;
    assign eval_red_y   = red_potted_q ? 11'(RED_RESPAWN_Y) : red_y_loc;
    assign eval_white_x = white_potted_q ? 11'(WHITE_RESPAWN_X) : white_x_loc;
    assign eval_white_y = white_potted_q ? 11'(WHITE_RESPAWN_Y) : white_y_loc;

    always_comb begin
        state_d = state_q;
        case (state_q)
            AIM:     if (shot_fired) state_d = ROLL;
            ROLL: begin
                if (timeout) begin
                    state_d = EVAL;
                end else if (startOfFrame && roll_cnt_q == CW'(MIN_ROLL_FRAMES - 1)) begin
                    state_d = SETTLE;
                end
            end
            SETTLE:  if (timeout || settle_done) state_d = EVAL;
            EVAL:    state_d = win ? OVER : AIM;
            OVER:    state_d = OVER;
            default: state_d = AIM;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= AIM;
            roll_cnt_q     <= '0;
            settle_cnt_q   <= '0;
            red_potted_q   <= 1'b0;
            white_potted_q <= 1'b0;
            player_q       <= 1'b0;
            score0_q       <= '0;
            score1_q       <= '0;
            hold_red_x_q   <= '0;
            hold_red_y_q   <= '0;
            hold_white_x_q <= '0;
            hold_white_y_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == AIM && shot_fired) begin
                roll_cnt_q     <= '0;
                settle_cnt_q   <= '0;
                red_potted_q   <= 1'b0;
                white_potted_q <= 1'b0;
            end
            if (rolling) begin
                red_potted_q   <= red_potted_q | collision_Red_Black;
                white_potted_q <= white_potted_q | collision_White_Black;
            end
            if (state_q == ROLL && startOfFrame) begin
                roll_cnt_q <= roll_cnt_q + 1'b1;
            end
            // Any low stopped flag, even between frames, restarts the settle run.
            if (state_q == SETTLE) begin
                if (!both_stopped) begin
                    settle_cnt_q <= '0;
                end else if (startOfFrame) begin
                    settle_cnt_q <= settle_cnt_q + 1'b1;
                end
            end
            if (state_q == EVAL) begin
                score0_q       <= score0_d;
                score1_q       <= score1_d;
                player_q       <= player_q ^ toggle;
                hold_red_x_q   <= eval_red_x;
                hold_red_y_q   <= eval_red_y;
                hold_white_x_q <= eval_white_x;
                hold_white_y_q <= eval_white_y;
            end
        end
    end

    assign turn_over       = (state_q == EVAL);
    assign shot_enable     = (state_q == AIM);
    assign game_over       = (state_q == OVER);
    assign foul            = turn_over && white_potted_q;
    assign current_player  = player_q;
    assign score0          = score0_q;
    assign score1          = score1_q;
    assign new_red_x_loc   = turn_over ? eval_red_x : hold_red_x_q;
    assign new_red_y_loc   = turn_over ? eval_red_y : hold_red_y_q;
    assign new_white_x_loc = turn_over ? eval_white_x : hold_white_x_q;
    assign new_white_y_loc = turn_over ? eval_white_y : hold_white_y_q;

endmodule

// File: tb/tb_turn_manager.sv
// Bench for turn_manager: directed turns plus randomized turns against a rule-level game model.
// Compile both files with TURN_TIMEOUT_EN defined to exercise the timeout path.
module tb_turn_manager;
    localparam int MAX_T      = 10;
    localparam int FRAME_CLKS = 4;
    localparam int NF         = 40;
    localparam int MIN_ROLL   = 2;
    localparam int SETTLE     = 4;
    localparam int WIN        = 5;

    logic               clk = 1'b0;
    logic               resetN = 1'b0;
    logic               startOfFrame = 1'b0;
    logic               shot_fired = 1'b0;
    logic               red_ball_stopped = 1'b0;
    logic               white_ball_stopped = 1'b0;
    logic               collision_Red_Black = 1'b0;
    logic               collision_White_Black = 1'b0;
    logic signed [10:0] red_x_loc = '0, red_y_loc = '0, white_x_loc = '0, white_y_loc = '0;
    logic               turn_over, current_player, shot_enable, foul, game_over;
    logic signed [10:0] new_red_x_loc, new_red_y_loc, new_white_x_loc, new_white_y_loc;
    logic [3:0]         score0, score1;

    always #5 clk = ~clk;

    turn_manager #(.MAX_TURN_FRAMES(MAX_T)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .shot_fired(shot_fired),
        .red_ball_stopped(red_ball_stopped), .white_ball_stopped(white_ball_stopped),
        .collision_Red_Black(collision_Red_Black), .collision_White_Black(collision_White_Black),
        .red_x_loc(red_x_loc), .red_y_loc(red_y_loc),
        .white_x_loc(white_x_loc), .white_y_loc(white_y_loc),
        .turn_over(turn_over),
        .new_red_x_loc(new_red_x_loc), .new_red_y_loc(new_red_y_loc),
        .new_white_x_loc(new_white_x_loc), .new_white_y_loc(new_white_y_loc),
        .current_player(current_player), .score0(score0), .score1(score1),
        .shot_enable(shot_enable), .foul(foul), .game_over(game_over)
    );

    int checks = 0;
    int errors = 0;
    int m_score [2];
    int m_player;
    bit m_over;
    bit stop_r [1:NF];
    bit stop_w [1:NF];
    int cur_frame = 0;
    int to_total = 0;
    int to_frame = 0;
    logic               cap_foul;
    logic signed [10:0] cap_rx, cap_ry, cap_wx, cap_wy;

    // Record every turn_over cycle and the outputs that accompany it.
    always @(negedge clk) begin
        if (turn_over === 1'b1) begin
            to_total++;
            to_frame = cur_frame;
            cap_foul = foul;
            cap_rx   = new_red_x_loc;
            cap_ry   = new_red_y_loc;
            cap_wx   = new_white_x_loc;
            cap_wy   = new_white_y_loc;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic nstep();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        startOfFrame = 1'b0;
        shot_fired = 1'b0;
        collision_Red_Black = 1'b0;
        collision_White_Black = 1'b0;
        nstep();
        resetN = 1'b1;
        nstep();
        m_score[0] = 0;
        m_score[1] = 0;
        m_player = 0;
        m_over = 1'b0;
    endtask

    task automatic fill_stops(input int mode);
        for (int j = 1; j <= NF; j++) begin
            if (mode == 0) begin
                stop_r[j] = 1'b1;
                stop_w[j] = 1'b1;
            end else if (mode == 1) begin
                stop_r[j] = 1'b0;
                stop_w[j] = 1'b0;
            end else begin
                stop_r[j] = (j > NF - SETTLE) || ($urandom_range(0, 4) != 0);
                stop_w[j] = (j > NF - SETTLE) || ($urandom_range(0, 4) != 0);
            end
        end
    endtask

    // Turn ends on the first frame closing a run of SETTLE jointly stopped frames after the roll.
    function automatic int model_end(input int nframes);
        int run = 0;
        int e = 0;
        for (int k = 1; k <= nframes; k++) begin
            if (k > MIN_ROLL && stop_r[k] && stop_w[k]) run++;
            else run = 0;
            if (e == 0 && run >= SETTLE) e = k;
        end
`ifdef TURN_TIMEOUT_EN
        if ((e == 0 || e > MAX_T) && nframes >= MAX_T) e = MAX_T;
`endif
        return e;
    endfunction

    task automatic play_turn(input bit pr, input bit pw, input int pot_frame, input int extra_shot,
                             input int nframes, input logic signed [10:0] rx,
                             input logic signed [10:0] ry, input logic signed [10:0] wx,
                             input logic signed [10:0] wy, input string tag);
        int exp_end, base, p;
        bit pr_eff, pw_eff;
        logic signed [10:0] erx, ery, ewx, ewy;
        exp_end = model_end(nframes);
        pr_eff = pr && exp_end > 0 && pot_frame <= exp_end;
        pw_eff = pw && exp_end > 0 && pot_frame <= exp_end;
        erx = pr_eff ? 11'sd280 : rx;
        ery = pr_eff ? 11'sd185 : ry;
        ewx = pw_eff ? 11'sd120 : wx;
        ewy = pw_eff ? 11'sd185 : wy;
        p = m_player;
        if (exp_end > 0) begin
            if (pr_eff) m_score[p] = (m_score[p] < 15) ? m_score[p] + 1 : 15;
            if (pw_eff) m_score[1-p] = (m_score[1-p] < 15) ? m_score[1-p] + 1 : 15;
            if (!pr_eff || pw_eff) m_player = 1 - p;
            m_over = (m_score[0] >= WIN) || (m_score[1] >= WIN);
        end
        red_x_loc = rx;
        red_y_loc = ry;
        white_x_loc = wx;
        white_y_loc = wy;
        base = to_total;
        checks++;
        if (shot_enable !== 1'b1) begin
            errors++;
            $display("FAIL %s shot_enable before shot: got %b want 1", tag, shot_enable);
        end
        shot_fired = 1'b1;
        nstep();
        shot_fired = 1'b0;
        for (int j = 1; j <= nframes; j++) begin
            startOfFrame = 1'b0;
            if (to_total != base) break;
            red_ball_stopped = stop_r[j];
            white_ball_stopped = stop_w[j];
            for (int c = 1; c < FRAME_CLKS; c++) begin
                collision_Red_Black = pr && j == pot_frame && c == 1;
                collision_White_Black = pw && j == pot_frame && c == 1;
                shot_fired = (j == extra_shot) && c == 2;
                nstep();
            end
            collision_Red_Black = 1'b0;
            collision_White_Black = 1'b0;
            shot_fired = 1'b0;
            cur_frame = j;
            startOfFrame = 1'b1;
            nstep();
        end
        startOfFrame = 1'b0;
        nstep();
        if (exp_end > 0) begin
            checks++;
            if (to_total - base != 1) begin
                errors++;
                $display("FAIL %s turn_over cycles: got %0d want 1", tag, to_total - base);
            end
            checks++;
            if (to_frame != exp_end) begin
                errors++;
                $display("FAIL %s turn_over frame: got %0d want %0d", tag, to_frame, exp_end);
            end
            checks++;
            if (cap_foul !== pw_eff) begin
                errors++;
                $display("FAIL %s foul: got %b want %b", tag, cap_foul, pw_eff);
            end
            checks++;
            if ({cap_rx, cap_ry} !== {erx, ery}) begin
                errors++;
                $display("FAIL %s new_red: got (%0d,%0d) want (%0d,%0d)", tag, cap_rx, cap_ry,
                         erx, ery);
            end
            checks++;
            if ({cap_wx, cap_wy} !== {ewx, ewy}) begin
                errors++;
                $display("FAIL %s new_white: got (%0d,%0d) want (%0d,%0d)", tag, cap_wx, cap_wy,
                         ewx, ewy);
            end
            checks++;
            if (score0 !== 4'(m_score[0]) || score1 !== 4'(m_score[1])) begin
                errors++;
                $display("FAIL %s scores: got %0d/%0d want %0d/%0d", tag, score0, score1,
                         m_score[0], m_score[1]);
            end
            checks++;
            if (current_player !== 1'(m_player)) begin
                errors++;
                $display("FAIL %s player: got %b want %0d", tag, current_player, m_player);
            end
            checks++;
            if ({game_over, shot_enable} !== {m_over, !m_over}) begin
                errors++;
                $display("FAIL %s game_over/shot_enable: got %b%b want %b%b", tag, game_over,
                         shot_enable, m_over, !m_over);
            end
            checks++;
            if ({new_red_x_loc, new_red_y_loc, new_white_x_loc, new_white_y_loc} !==
                {erx, ery, ewx, ewy}) begin
                errors++;
                $display("FAIL %s held locations: got (%0d,%0d,%0d,%0d) want (%0d,%0d,%0d,%0d)",
                         tag, new_red_x_loc, new_red_y_loc, new_white_x_loc, new_white_y_loc,
                         erx, ery, ewx, ewy);
            end
        end else begin
            checks++;
            if (to_total != base) begin
                errors++;
                $display("FAIL %s unexpected turn_over: got %0d pulses want 0", tag,
                         to_total - base);
            end
            checks++;
            if (shot_enable !== 1'b0) begin
                errors++;
                $display("FAIL %s still in turn: shot_enable got %b want 0", tag, shot_enable);
            end
        end
    endtask

    task automatic test_reset();
        shot_fired = 1'b1;
        collision_Red_Black = 1'b1;
        do_reset();
        checks++;
        if ({turn_over, foul, game_over, current_player, shot_enable} !== 5'b00001) begin
            errors++;
            $display("FAIL reset flags: got %b%b%b%b%b want 00001", turn_over, foul, game_over,
                     current_player, shot_enable);
        end
        checks++;
        if ({score1, score0} !== 8'd0) begin
            errors++;
            $display("FAIL reset scores: got %0d/%0d want 0/0", score0, score1);
        end
        checks++;
        if ({new_red_x_loc, new_red_y_loc, new_white_x_loc, new_white_y_loc} !== 44'd0) begin
            errors++;
            $display("FAIL reset locations: got (%0d,%0d,%0d,%0d) want zeros", new_red_x_loc,
                     new_red_y_loc, new_white_x_loc, new_white_y_loc);
        end
    endtask

    task automatic test_pots();
        do_reset();
        fill_stops(0);
        play_turn(1'b0, 1'b0, 0, 0, NF, 11'sd300, 11'sd200, 11'sd100, 11'sd150, "no_pot");
        do_reset();
        play_turn(1'b1, 1'b0, 1, 0, NF, 11'sd400, 11'sd220, 11'sd50, 11'sd60, "red_pot");
        do_reset();
        play_turn(1'b0, 1'b1, 2, 0, NF, 11'sd310, 11'sd90, 11'sd500, 11'sd70, "white_pot");
        play_turn(1'b1, 1'b1, 3, 0, NF, 11'sd20, 11'sd30, 11'sd40, 11'sd50, "both_pot");
    endtask

    task automatic test_flicker();
        do_reset();
        fill_stops(0);
        stop_r[MIN_ROLL + 3] = 1'b0;
        play_turn(1'b0, 1'b0, 0, MIN_ROLL + 2, NF, 11'sd123, 11'sd45, 11'sd67, 11'sd89,
                  "flicker");
    endtask

    task automatic test_win();
        int base;
        do_reset();
        fill_stops(0);
        for (int i = 0; i < WIN; i++) begin
            play_turn(1'b1, 1'b0, 1, 0, NF, 11'sd200, 11'sd100, 11'sd150, 11'sd160, "win");
        end
        base = to_total;
        shot_fired = 1'b1;
        nstep();
        shot_fired = 1'b0;
        for (int j = 0; j < 12 * FRAME_CLKS; j++) begin
            startOfFrame = (j % FRAME_CLKS) == 0;
            nstep();
        end
        startOfFrame = 1'b0;
        checks++;
        if (to_total != base || game_over !== 1'b1 || shot_enable !== 1'b0) begin
            errors++;
            $display("FAIL over sticky: got pulses=%0d game_over=%b shot_enable=%b want 0 1 0",
                     to_total - base, game_over, shot_enable);
        end
    endtask

    task automatic test_reset_mid_roll();
        do_reset();
        fill_stops(0);
        play_turn(1'b1, 1'b0, 1, 0, NF, 11'sd10, 11'sd20, 11'sd30, 11'sd40, "pre_reset");
        shot_fired = 1'b1;
        nstep();
        shot_fired = 1'b0;
        startOfFrame = 1'b1;
        nstep();
        startOfFrame = 1'b0;
        resetN = 1'b0;
        #2;
        checks++;
        if ({shot_enable, score0, score1, current_player, game_over} !== {1'b1, 10'd0}) begin
            errors++;
            $display("FAIL mid_roll reset: got se=%b s0=%0d s1=%0d p=%b go=%b want 1 0 0 0 0",
                     shot_enable, score0, score1, current_player, game_over);
        end
        nstep();
        resetN = 1'b1;
        nstep();
        m_score[0] = 0;
        m_score[1] = 0;
        m_player = 0;
        m_over = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        fill_stops(1);
        play_turn(1'b0, 1'b0, 0, 0, 3 * MAX_T, 11'sd77, 11'sd88, 11'sd99, 11'sd111, "timeout");
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 40; t++) begin
            if (m_over) do_reset();
            fill_stops(2);
            play_turn($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(1, 8), $urandom_range(0, 12), NF,
                      11'($urandom_range(0, 620)), 11'($urandom_range(0, 460)),
                      11'($urandom_range(0, 620)), 11'($urandom_range(0, 460)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_pots();
        test_flicker();
        test_win();
        test_reset_mid_roll();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
